tdoa_sched: RTL and testbench
=============================

Name: tdoa_sched

Overview:
- Frame scheduler between the three processor arrays (delay indices A/B/C) and a single shared downstream consumer, such as an angle solver or serial link.
- Detects each NDATA-sample frame boundary from the master counter and snapshots the three delay indices.
- Discards warm-up frames after reset.
- Serializes A, B, C to the consumer over one valid/ready channel, tagged with channel and frame number.
- Counts frames lost because the consumer was too slow.

Parameters:
NDATA, 128, samples per frame (counter modulus)
NDATA_LOG, $clog2(NDATA), width of counter and delay indices
SKIP, 2, frame boundaries ignored after reset (pipeline fill)
FRAME_W, 8, frame tag width
OVF_W, 4, overrun counter width (saturating)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
ena  in  1  global enable from reset synchronizer
cntin  in  NDATA_LOG  master sample counter
dIdA  in  NDATA_LOG  delay index, channel A
dIdB  in  NDATA_LOG  delay index, channel B
dIdC  in  NDATA_LOG  delay index, channel C
dout_valid  out  1  output word valid
dout_ready  in  1  consumer accepts word when high with dout_valid
dout_ch  out  2  channel tag: 0=A, 1=B, 2=C; 3 never driven
dout_data  out  NDATA_LOG  delay index of tagged channel
dout_frame  out  FRAME_W  frame number of current word
busy  out  1  high in SEND_A/SEND_B/SEND_C
ovf_cnt  out  OVF_W  dropped-frame count, saturates at all-ones

Behaviour:
- Reset: rst low at a rising edge puts the block in WARMUP and clears the following:
  - dout_valid, dout_ch, dout_data, dout_frame, busy, ovf_cnt
  - skip counter, internal snapshot registers
- Reset has priority over every other event, including mid-transfer. dout_valid is low the cycle after the reset edge.
- Boundary event: bnd = ena & (cntin == NDATA-1), evaluated each cycle. When ena is low no boundary is seen; the handshake still proceeds.
- States: WARMUP, IDLE, SEND_A, SEND_B, SEND_C.
- WARMUP:
  - Each bnd increments the skip counter.
  - The bnd that brings the count to SKIP moves to IDLE and captures nothing.
  - SKIP=0 means go to IDLE on the first cycle after reset.
- Capture, on an accepted bnd:
  - Snapshot dIdA/B/C as sampled on the bnd cycle.
  - Go to SEND_A on the next edge.
  - dout_frame takes the frame counter value; the frame counter then increments, wrapping modulo 2^FRAME_W.
- IDLE: bnd is accepted (capture).
- SEND_A:
  - dout_valid=1, dout_ch=0, dout_data=snapA.
  - On valid&ready go to SEND_B.
- SEND_B: same as SEND_A with ch=1 and snapB; on valid&ready go to SEND_C.
- SEND_C:
  - ch=2, snapC.
  - On valid&ready go to IDLE, or to SEND_A with a fresh capture if bnd is high in the same cycle.
- Latency: bnd on cycle T gives dout_valid=1, ch=0 registered at T+1. With ready held high, A/B/C appear on T+1, T+2, T+3.
- Stability: while dout_valid=1 and dout_ready=0, dout_ch, dout_data and dout_frame hold their values. dout_valid never drops without a handshake, except on reset.
- Overrun: bnd while in SEND_A, SEND_B, or SEND_C-without-handshake causes the following:
  - The new frame is dropped and snapshots are unchanged.
  - ovf_cnt increments, saturating.
  - The frame counter still increments, so the consumer sees a tag gap.
- Boundary coincident with the SEND_C handshake is not an overrun.
- dout_ready is ignored when dout_valid=0.
- All outputs are registered. No combinational path from dout_ready to dout_valid.

Test Plan:
- Warm-up (NDATA=128, SKIP=2, ena=1, ready=1; counter free-runs from reset) -> first two cntin=127 events produce no output. At the third, dIdA/B/C=5/17/90 give words (ch0,5),(ch1,17),(ch2,90) with frame=0 on the three cycles after bnd. Second frame tag=1.
- Backpressure (ready low 10 cycles during SEND_B) -> ch=1, data and frame held constant all 10 cycles. Transfer resumes with ch=1 accepted, then ch=2. No duplicate or skipped word.
- Overrun (ready=0 across a full frame after a capture) -> ovf_cnt=1 and snapshot retained. After ready=1 the old frame finishes, and the next captured frame is tagged +2. With 20 consecutive drops, ovf_cnt saturates at 15.
- Coincident boundary (ready asserted so the SEND_C handshake lands exactly on cntin=127) -> next cycle SEND_A with new data, ovf_cnt unchanged.
- ena gating (ena=0 while cntin passes 127) -> no capture, no warm-up progress, and a pending transfer still completes on ready.
- Mid-transfer reset (rst=0 for 1 cycle in SEND_B) -> next cycle valid=0, busy=0, ovf_cnt=0, frame tag restarts at 0 after SKIP boundaries.

Source files
------------

// File: rtl/tdoa_sched_if.sv
// Output channel of the TDOA frame scheduler: one word per handshake,
// carrying a delay index tagged with its channel and frame number.
interface tdoa_sched_if #(
    parameter int NDATA_LOG = 7,
    parameter int FRAME_W   = 8
);
    logic                 dout_valid;
    logic                 dout_ready;
    logic [1:0]           dout_ch;
    logic [NDATA_LOG-1:0] dout_data;
    logic [FRAME_W-1:0]   dout_frame;

    modport master (
        output dout_valid,
        output dout_ch,
        output dout_data,
        output dout_frame,
        input  dout_ready
    );

    modport slave (
        input  dout_valid,
        input  dout_ch,
        input  dout_data,
        input  dout_frame,
        output dout_ready
    );
endinterface

// File: rtl/tdoa_sched.sv
// Frame scheduler: snapshots the three delay indices at each frame boundary
// (after a warm-up period) and serializes them A, B, C to one consumer.
// Boundaries that arrive while a frame is still being sent are dropped and
// counted in a saturating overrun counter.
module tdoa_sched #(
    parameter int NDATA     = 128,
    parameter int NDATA_LOG = $clog2(NDATA),
    parameter int SKIP      = 2,
    parameter int FRAME_W   = 8,
    parameter int OVF_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [NDATA_LOG-1:0] cntin,
    input  logic [NDATA_LOG-1:0] dIdA,
    input  logic [NDATA_LOG-1:0] dIdB,
    input  logic [NDATA_LOG-1:0] dIdC,
    tdoa_sched_if.master         dout,
    output logic                 busy,
    output logic [OVF_W-1:0]     ovf_cnt
);

    localparam logic [2:0] WARMUP = 3'd0;
    localparam logic [2:0] IDLE   = 3'd1;
    localparam logic [2:0] SEND_A = 3'd2;
    localparam logic [2:0] SEND_B = 3'd3;
    localparam logic [2:0] SEND_C = 3'd4;

    localparam int SKIP_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [NDATA_LOG-1:0] CNT_LAST = NDATA_LOG'(NDATA - 1);

    logic [2:0]           state, stateNxt;
    logic [SKIP_W-1:0]    skipCnt, skipNxt;
    logic [FRAME_W-1:0]   frameCnt, frameCntNxt;
    logic [FRAME_W-1:0]   frameTagNxt;
    logic [NDATA_LOG-1:0] snapA, snapB, snapC;
    logic [NDATA_LOG-1:0] snapANxt, snapBNxt, snapCNxt;
    logic [OVF_W-1:0]     ovfNxt;
    logic                 bnd;
    logic                 hs;
    logic                 capture;
    logic                 drop;

    // Saturating increment for the overrun counter.
    function automatic logic [OVF_W-1:0] satInc(input logic [OVF_W-1:0] v);
        return (&v) ? v : v + OVF_W'(1);
    endfunction

    assign bnd = ena && (cntin == CNT_LAST);
    assign hs  = dout.dout_valid && dout.dout_ready;

    // Next-state, capture and overrun decisions for the current cycle.
    always_comb begin
        stateNxt    = state;
        skipNxt     = skipCnt;
        frameCntNxt = frameCnt;
        frameTagNxt = dout.dout_frame;
        snapANxt    = snapA;
        snapBNxt    = snapB;
        snapCNxt    = snapC;
        ovfNxt      = ovf_cnt;
        capture     = 1'b0;
        drop        = 1'b0;

        case (state)
            WARMUP: begin
                if (SKIP == 0) begin
                    stateNxt = IDLE;
                end else if (bnd) begin
                    skipNxt = skipCnt + SKIP_W'(1);
                    if (skipCnt == SKIP_LAST) begin
                        stateNxt = IDLE;
                    end
                end
            end
            IDLE: begin
                capture = bnd;
            end
            SEND_A: begin
                drop = bnd;
                if (hs) begin
                    stateNxt = SEND_B;
                end
            end
            SEND_B: begin
                drop = bnd;
                if (hs) begin
                    stateNxt = SEND_C;
                end
            end
            SEND_C: begin
                // A boundary landing on the final handshake starts the next
                // frame immediately instead of counting as an overrun.
                if (hs) begin
                    if (bnd) begin
                        capture = 1'b1;
                    end else begin
                        stateNxt = IDLE;
                    end
                end else begin
                    drop = bnd;
                end
            end
            default: begin
                stateNxt = WARMUP;
            end
        endcase

        if (capture) begin
            stateNxt    = SEND_A;
            snapANxt    = dIdA;
            snapBNxt    = dIdB;
            snapCNxt    = dIdC;
            frameTagNxt = frameCnt;
            frameCntNxt = frameCnt + FRAME_W'(1);
        end

        // Dropped frames still consume a frame number so gaps are visible.
        if (drop) begin
            frameCntNxt = frameCnt + FRAME_W'(1);
            ovfNxt      = satInc(ovf_cnt);
        end
    end

    // Control state, counters and snapshot registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= WARMUP;
            skipCnt  <= '0;
            frameCnt <= '0;
            snapA    <= '0;
            snapB    <= '0;
            snapC    <= '0;
            ovf_cnt  <= '0;
        end else begin
            state    <= stateNxt;
            skipCnt  <= skipNxt;
            frameCnt <= frameCntNxt;
            snapA    <= snapANxt;
            snapB    <= snapBNxt;
            snapC    <= snapCNxt;
            ovf_cnt  <= ovfNxt;
        end
    end

    // Registered output word, decoded from the state being entered so that
    // valid/ch/data line up with the state on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout.dout_valid <= 1'b0;
            dout.dout_ch    <= 2'd0;
            dout.dout_data  <= '0;
            dout.dout_frame <= '0;
            busy            <= 1'b0;
        end else begin
            dout.dout_frame <= frameTagNxt;
            case (stateNxt)
                SEND_A: begin
                    dout.dout_valid <= 1'b1;
                    busy            <= 1'b1;
                    dout.dout_ch    <= 2'd0;
                    dout.dout_data  <= snapANxt;
                end
                SEND_B: begin
                    dout.dout_valid <= 1'b1;
                    busy            <= 1'b1;
                    dout.dout_ch    <= 2'd1;
                    dout.dout_data  <= snapBNxt;
                end
                SEND_C: begin
                    dout.dout_valid <= 1'b1;
                    busy            <= 1'b1;
                    dout.dout_ch    <= 2'd2;
                    dout.dout_data  <= snapCNxt;
                end
                default: begin
                    dout.dout_valid <= 1'b0;
                    busy            <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdoa_sched.sv
// Testbench for tdoa_sched: table-driven word sequences plus hand-written
// multi-cycle scenarios (overrun, coincident boundary, ena gating, reset).
module tb_tdoa_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [6:0] cntin;
    logic [6:0] dIdA, dIdB, dIdC;
    logic       busy;
    logic [3:0] ovf_cnt;

    int checks = 0;
    int errors = 0;
    logic sawValid = 1'b0;

    tdoa_sched_if #(.NDATA_LOG(7), .FRAME_W(8)) doutIf ();

    tdoa_sched #(
        .NDATA(128), .SKIP(2), .FRAME_W(8), .OVF_W(4)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .cntin(cntin),
        .dIdA(dIdA), .dIdB(dIdB), .dIdC(dIdC),
        .dout(doutIf), .busy(busy), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rdy;
        logic       expV;
        logic [1:0] expCh;
        logic [6:0] expD;
        logic [7:0] expF;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic r, input logic v, input logic [1:0] c,
                          input logic [6:0] d, input logic [7:0] f);
        vec_t t;
        t.rdy = r; t.expV = v; t.expCh = c; t.expD = d; t.expF = f;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: outputs are sampled 1 time unit after the edge, then the
    // free-running sample counter advances for the next cycle.
    task automatic step();
        @(posedge clk);
        #1;
        if (doutIf.dout_valid) sawValid = 1'b1;
        cntin = cntin + 7'd1;
    endtask

    // Advance until the pending cycle has cntin == 127 (bounded by the wrap).
    task automatic goToBnd();
        for (int i = 0; i < 130 && cntin != 7'd127; i++) step();
        check("goToBnd_reach", {25'd0, cntin}, 32'd127);
    endtask

    task automatic expectWord(input string name, input logic [1:0] c,
                              input logic [6:0] d, input logic [7:0] f);
        check({name, "_valid"}, {31'd0, doutIf.dout_valid}, 32'd1);
        check({name, "_busy"},  {31'd0, busy}, 32'd1);
        check({name, "_ch"},    {30'd0, doutIf.dout_ch}, {30'd0, c});
        check({name, "_data"},  {25'd0, doutIf.dout_data}, {25'd0, d});
        check({name, "_frame"}, {24'd0, doutIf.dout_frame}, {24'd0, f});
    endtask

    task automatic runVec(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            doutIf.dout_ready = vecs[i].rdy;
            if (vecs[i].expV) begin
                expectWord($sformatf("vec%0d", i), vecs[i].expCh, vecs[i].expD, vecs[i].expF);
            end else begin
                check($sformatf("vec%0d_valid", i), {31'd0, doutIf.dout_valid}, 32'd0);
                check($sformatf("vec%0d_busy", i),  {31'd0, busy}, 32'd0);
            end
            step();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Frame 0 after warm-up (0..3)
        addVec(1, 1, 0, 5, 0);  addVec(1, 1, 1, 17, 0);
        addVec(1, 1, 2, 90, 0); addVec(1, 0, 0, 0, 0);
        // Frame 1 with 10 cycles of backpressure in SEND_B (4..17)
        addVec(1, 1, 0, 7, 1);
        for (int i = 0; i < 10; i++) addVec(0, 1, 1, 20, 1);
        addVec(1, 1, 1, 20, 1); addVec(1, 1, 2, 33, 1); addVec(1, 0, 0, 0, 0);
        // Frame 2 drained after an overrun (18..21)
        addVec(1, 1, 0, 1, 2);  addVec(1, 1, 1, 2, 2);
        addVec(1, 1, 2, 3, 2);  addVec(1, 0, 0, 0, 0);
        // Frame 4, tag jumped past the dropped frame 3 (22..25)
        addVec(1, 1, 0, 9, 4);  addVec(1, 1, 1, 10, 4);
        addVec(1, 1, 2, 11, 4); addVec(1, 0, 0, 0, 0);

        rst = 1'b0; ena = 1'b1; cntin = 7'd0;
        dIdA = 7'd0; dIdB = 7'd0; dIdC = 7'd0;
        doutIf.dout_ready = 1'b1;
        step(); step();
        check("rst_valid", {31'd0, doutIf.dout_valid}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_ovf",   {28'd0, ovf_cnt}, 32'd0);
        check("rst_frame", {24'd0, doutIf.dout_frame}, 32'd0);
        check("rst_data",  {25'd0, doutIf.dout_data}, 32'd0);
        rst = 1'b1; cntin = 7'd0;

        // Warm-up: two boundaries produce nothing, third captures
        sawValid = 1'b0;
        goToBnd(); step();
        goToBnd(); step();
        goToBnd();
        check("warmup_noOutput", {31'd0, sawValid}, 32'd0);
        dIdA = 7'd5; dIdB = 7'd17; dIdC = 7'd90;
        step();
        runVec(0, 3);

        // Backpressure during SEND_B
        goToBnd();
        dIdA = 7'd7; dIdB = 7'd20; dIdC = 7'd33;
        step();
        runVec(4, 17);

        // Overrun: consumer stalls across a full frame
        goToBnd();
        dIdA = 7'd1; dIdB = 7'd2; dIdC = 7'd3;
        step();
        doutIf.dout_ready = 1'b0;
        goToBnd();
        dIdA = 7'd40; dIdB = 7'd41; dIdC = 7'd42;
        step();
        check("ovr_cnt", {28'd0, ovf_cnt}, 32'd1);
        expectWord("ovr_hold", 2'd0, 7'd1, 8'd2);
        runVec(18, 21);
        goToBnd();
        dIdA = 7'd9; dIdB = 7'd10; dIdC = 7'd11;
        step();
        runVec(22, 25);

        // SEND_C handshake coincident with the boundary
        goToBnd();
        dIdA = 7'd50; dIdB = 7'd51; dIdC = 7'd52;
        step();
        doutIf.dout_ready = 1'b0;
        for (int i = 0; i < 130 && cntin != 7'd125; i++) step();
        doutIf.dout_ready = 1'b1;
        expectWord("coin_a", 2'd0, 7'd50, 8'd5); step();
        expectWord("coin_b", 2'd1, 7'd51, 8'd5); step();
        check("coin_cnt127", {25'd0, cntin}, 32'd127);
        expectWord("coin_c", 2'd2, 7'd52, 8'd5);
        dIdA = 7'd60; dIdB = 7'd61; dIdC = 7'd62;
        step();
        expectWord("coin_newA", 2'd0, 7'd60, 8'd6);
        check("coin_ovf", {28'd0, ovf_cnt}, 32'd1);
        step();
        expectWord("coin_newB", 2'd1, 7'd61, 8'd6); step();
        expectWord("coin_newC", 2'd2, 7'd62, 8'd6); step();
        check("coin_idle", {31'd0, doutIf.dout_valid}, 32'd0);

        // ena low over a boundary while a transfer is pending
        goToBnd();
        dIdA = 7'd3; dIdB = 7'd4; dIdC = 7'd5;
        step();
        doutIf.dout_ready = 1'b0;
        goToBnd();
        ena = 1'b0; dIdA = 7'd99;
        step();
        ena = 1'b1;
        check("ena_ovf", {28'd0, ovf_cnt}, 32'd1);
        doutIf.dout_ready = 1'b1;
        expectWord("ena_a", 2'd0, 7'd3, 8'd7); step();
        expectWord("ena_b", 2'd1, 7'd4, 8'd7); step();
        expectWord("ena_c", 2'd2, 7'd5, 8'd7); step();
        check("ena_idle", {31'd0, doutIf.dout_valid}, 32'd0);

        // Reset in the middle of a transfer
        goToBnd();
        dIdA = 7'd11; dIdB = 7'd12; dIdC = 7'd13;
        step();
        expectWord("mid_a", 2'd0, 7'd11, 8'd8); step();
        expectWord("mid_b", 2'd1, 7'd12, 8'd8);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("mid_valid", {31'd0, doutIf.dout_valid}, 32'd0);
        check("mid_busy",  {31'd0, busy}, 32'd0);
        check("mid_ovf",   {28'd0, ovf_cnt}, 32'd0);

        // Warm-up again; a boundary with ena low does not count
        sawValid = 1'b0;
        goToBnd(); ena = 1'b0; step(); ena = 1'b1;
        goToBnd(); step();
        goToBnd(); step();
        goToBnd();
        check("rewarm_noOutput", {31'd0, sawValid}, 32'd0);
        dIdA = 7'd21; dIdB = 7'd22; dIdC = 7'd23;
        doutIf.dout_ready = 1'b0;
        step();
        expectWord("sat_first", 2'd0, 7'd21, 8'd0);

        // 20 consecutive dropped frames saturate the overrun counter
        for (int k = 1; k <= 20; k++) begin
            goToBnd();
            dIdA = 7'(k); dIdB = 7'(k); dIdC = 7'(k);
            step();
            if (k == 14) check("sat_ovf14", {28'd0, ovf_cnt}, 32'd14);
            if (k == 15) check("sat_ovf15", {28'd0, ovf_cnt}, 32'd15);
        end
        check("sat_ovf20", {28'd0, ovf_cnt}, 32'd15);
        expectWord("sat_hold", 2'd0, 7'd21, 8'd0);
        doutIf.dout_ready = 1'b1;
        step();
        expectWord("sat_b", 2'd1, 7'd22, 8'd0); step();
        expectWord("sat_c", 2'd2, 7'd23, 8'd0); step();
        check("sat_idle", {31'd0, doutIf.dout_valid}, 32'd0);
        goToBnd();
        dIdA = 7'd1; dIdB = 7'd2; dIdC = 7'd3;
        step();
        expectWord("sat_nextTag", 2'd0, 7'd1, 8'd21);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
